// File: rtl/mash_ncl_if.sv
// Sample-side and result-side signals of the MASH 1-1-1 noise-cancellation recombiner.
// The master drives the carries and controls. The slave returns offset and window results.
interface mash_ncl_if #(
  parameter int P_WIN_LOG2 = 8
);
  logic                    i_en;
  logic                    i_quantize1;
  logic                    i_quantize2;
  logic                    i_quantize3;
  logic                    i_win_clr;
  logic [3:0]              o_div_offset;
  logic                    o_valid;
  logic [P_WIN_LOG2+3:0]   o_win_sum;
  logic                    o_win_valid;

  modport master (
    output i_en, i_quantize1, i_quantize2, i_quantize3, i_win_clr,
    input  o_div_offset, o_valid, o_win_sum, o_win_valid
  );

  modport slave (
    input  i_en, i_quantize1, i_quantize2, i_quantize3, i_win_clr,
    output o_div_offset, o_valid, o_win_sum, o_win_valid
  );
endinterface

// File: rtl/mash_ncl_combiner.sv
// MASH 1-1-1 recombiner y = c1 z^-2 + c2 (1-z^-1) z^-1 + c3 (1-z^-1)^2 plus a windowed sum of y.
// Latency is 2 enabled edges from carry in to o_div_offset. There is no backpressure: all state holds while i_en is low.
module mash_ncl_combiner #(
  parameter int P_WIN_LOG2 = 8
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  mash_ncl_if.slave bus
);
  localparam int SW = P_WIN_LOG2 + 4;

  // Each history entry is {c3, c2, c1}.
  logic [2:0]            s0, s1, s2;
  logic [1:0]            start_cnt;
  logic [P_WIN_LOG2-1:0] win_cnt;
  logic [SW-1:0]         acc;
  logic [3:0]            div_offset;
  logic                  valid;
  logic [SW-1:0]         win_sum;
  logic                  win_valid;
  logic [3:0]            y;
  logic [SW-1:0]         y_ext;
  logic                  acc_en;

  // Modulo-16 arithmetic is exact here because y is always within -3..+4.
  always_comb begin
    y = 4'(s2[0])
      + 4'(s1[1]) - 4'(s2[1])
      + 4'(s0[2]) - {2'b00, s1[2], 1'b0} + 4'(s2[2]);
    y_ext  = {{P_WIN_LOG2{y[3]}}, y};
    acc_en = bus.i_en && (start_cnt == 2'd3);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s0         <= '0;
      s1         <= '0;
      s2         <= '0;
      start_cnt  <= '0;
      win_cnt    <= '0;
      acc        <= '0;
      div_offset <= '0;
      valid      <= 1'b0;
      win_sum    <= '0;
      win_valid  <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      if (bus.i_en) begin
        s2         <= s1;
        s1         <= s0;
        s0         <= {bus.i_quantize3, bus.i_quantize2, bus.i_quantize1};
        div_offset <= y;
        if (start_cnt != 2'd3) begin
          start_cnt <= start_cnt + 2'd1;
        end else begin
          valid <= 1'b1;
        end
      end
      // A clear discards the sample on the same edge, including a window end.
      if (bus.i_win_clr) begin
        acc     <= '0;
        win_cnt <= '0;
      end else if (acc_en) begin
        if (win_cnt == {P_WIN_LOG2{1'b1}}) begin
          win_sum   <= acc + y_ext;
          win_valid <= 1'b1;
          acc       <= '0;
          win_cnt   <= '0;
        end else begin
          acc     <= acc + y_ext;
          win_cnt <= win_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.o_div_offset = div_offset;
  assign bus.o_valid      = valid;
  assign bus.o_win_sum    = win_sum;
  assign bus.o_win_valid  = win_valid;
endmodule

// File: tb/tb_mash_ncl_combiner.sv
// Directed bench for mash_ncl_combiner: hand-computed offsets, valid timing, window pulses, clear and async reset.
module tb_mash_ncl_combiner;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   ne;
  logic en_c;
  logic [2:0] smp [10];
  logic [2:0] s;

  always #5 clk = ~clk;

  mash_ncl_if #(.P_WIN_LOG2(W)) bus();

  mash_ncl_combiner #(.P_WIN_LOG2(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic c1, input logic c2, input logic c3, input logic clr);
    bus.i_en        = en;
    bus.i_quantize1 = c1;
    bus.i_quantize2 = c2;
    bus.i_quantize3 = c3;
    bus.i_win_clr   = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) smp[i] = 3'b000;
    smp[2] = 3'b101; smp[3] = 3'b010; smp[4] = 3'b100;
    smp[5] = 3'b010; smp[6] = 3'b100; smp[7] = 3'b000;

    // Reset state
    #2;
    chk("rst_div",   32'(bus.o_div_offset), 32'h0);
    chk("rst_valid", 32'(bus.o_valid),      32'h0);
    chk("rst_wsum",  32'(bus.o_win_sum),    32'h0);
    chk("rst_wv",    32'(bus.o_win_valid),  32'h0);
    #1;
    rst_n = 1'b1;

    // All-zero carries: window of zeros closes on edge 259
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 300; e++) begin
      tick();
      chk("zero_div",   32'(bus.o_div_offset), 32'h0);
      chk("zero_valid", 32'(bus.o_valid),      32'(e >= 4));
      chk("zero_wv",    32'(bus.o_win_valid),  32'(e == 259));
      if (e == 259) chk("zero_wsum", 32'(bus.o_win_sum), 32'h0);
    end

    // Constant c1: offset 1 once history is populated, window sum 256
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 270; e++) begin
      tick();
      if (e >= 4) chk("c1_div", 32'(bus.o_div_offset), 32'h1);
      chk("c1_wv", 32'(bus.o_win_valid), 32'(e == 259));
      if (e == 259) chk("c1_wsum", 32'(bus.o_win_sum), 32'd256);
    end

    // Single c3 pulse at sample 5 -> y[5..7] = +1,-2,+1
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      drive(1'b1, 1'b0, 1'b0, (e == 6), 1'b0);
      tick();
      chk("c3_pulse", 32'(bus.o_div_offset),
          (e == 7) ? 32'h1 : (e == 8) ? 32'hE : (e == 9) ? 32'h1 : 32'h0);
    end

    // Single c2 pulse at sample 5 -> y[6..7] = +1,-1
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      drive(1'b1, 1'b0, (e == 6), 1'b0, 1'b0);
      tick();
      chk("c2_pulse", 32'(bus.o_div_offset),
          (e == 8) ? 32'h1 : (e == 9) ? 32'hF : 32'h0);
    end

    // Extremes: y[4] = +4, y[7] = -3
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      s = smp[e-1];
      drive(1'b1, s[0], s[1], s[2], 1'b0);
      tick();
      if (e == 6) chk("max_pos", 32'(bus.o_div_offset), 32'h4);
      if (e == 9) chk("max_neg", 32'(bus.o_div_offset), 32'hD);
    end

    // Enable toggling every cycle with c1=1
    do_reset();
    ne = 0;
    for (int c = 1; c <= 600; c++) begin
      en_c = (c % 2 == 1);
      drive(en_c, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      if (en_c) ne++;
      chk("tog_div",   32'(bus.o_div_offset), 32'(ne >= 4));
      chk("tog_valid", 32'(bus.o_valid),      32'(ne >= 4));
      chk("tog_wv",    32'(bus.o_win_valid),  32'(en_c && ne == 259));
      if (en_c && ne == 259) chk("tog_wsum", 32'(bus.o_win_sum), 32'd256);
    end

    // Clear at window sample 100 restarts the window; the next pulse lands on edge 360
    do_reset();
    for (int e = 1; e <= 400; e++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, (e == 104));
      tick();
      chk("clr_wv", 32'(bus.o_win_valid), 32'(e == 360));
      if (e == 360) chk("clr_wsum", 32'(bus.o_win_sum), 32'd256);
    end

    // Asynchronous reset mid-window, away from any clock edge
    rst_n = 1'b0;
    #1;
    chk("arst_div",   32'(bus.o_div_offset), 32'h0);
    chk("arst_valid", 32'(bus.o_valid),      32'h0);
    chk("arst_wsum",  32'(bus.o_win_sum),    32'h0);
    chk("arst_wv",    32'(bus.o_win_valid),  32'h0);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("rearm_valid", 32'(bus.o_valid),      32'(e >= 4));
      chk("rearm_div",   32'(bus.o_div_offset), 32'(e >= 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
